// File: rtl/rx_rr_arbiter_if.sv
// Handshake bundle between the rx deserialisers, the round-robin arbiter
// and the router input FIFO, plus the grant-statistics readback.
interface rx_rr_arbiter_if #(
    parameter int ITEM_W = 8,
    parameter int STAT_W = 16
);
    logic [4:0]          rx_valid;
    logic [5*ITEM_W-1:0] rx_items;
    logic [4:0]          rx_read;
    logic                fifo_full;
    logic                fifo_write;
    logic [ITEM_W-1:0]   fifo_item;
    logic [2:0]          stat_sel;
    logic [STAT_W-1:0]   stat_count;

    // Arbiter side
    modport slave (
        input  rx_valid, rx_items, fifo_full, stat_sel,
        output rx_read, fifo_write, fifo_item, stat_count
    );

    // rx ports / FIFO / status reader side
    modport master (
        output rx_valid, rx_items, fifo_full, stat_sel,
        input  rx_read, fifo_write, fifo_item, stat_count
    );
endinterface

// File: rtl/rx_rr_arbiter.sv
// Round-robin arbiter sharing the router input FIFO write port among the
// five rx deserialisers (N, S, E, W, Local). One registered output slot
// decouples the rx pop handshake from the FIFO full flag.
// Optional per-port grant counters: define RX_ARB_STATS_EN.
module rx_rr_arbiter #(
    parameter int ITEM_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    rx_rr_arbiter_if.slave    arb
);

    logic [2:0]        r_ptr;
    logic              r_slot_valid;
    logic [ITEM_W-1:0] r_slot_data;

    logic [2:0]        w_ptr;
    logic              w_fifo_write;
    logic              w_accept;
    logic              w_grant_valid;
    logic [2:0]        w_grant_idx;
    logic [4:0]        w_rx_read;
    logic              w_pop;

    // (p + k) mod 5 for p in 0..4, k in 0..4
    function automatic logic [2:0] wrap5(input logic [2:0] p, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    // Unreachable pointer codes fall back to port 0
    assign w_ptr = (r_ptr > 3'd4) ? 3'd0 : r_ptr;

    assign w_fifo_write = r_slot_valid & ~arb.fifo_full;
    assign w_accept     = ~r_slot_valid | w_fifo_write;

    // Search from ptr upward; scan lowest priority first so the
    // highest-priority valid port is the last one written.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (arb.rx_valid[wrap5(w_ptr, 3'(k))]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = wrap5(w_ptr, 3'(k));
            end
        end
    end

    assign w_pop = w_accept & w_grant_valid;

    // One-hot pop pulse, only while the slot can take the item
    always_comb begin
        w_rx_read = '0;
        if (w_pop) w_rx_read[w_grant_idx] = 1'b1;
    end

    assign arb.rx_read    = w_rx_read;
    assign arb.fifo_write = w_fifo_write;
    assign arb.fifo_item  = r_slot_data;

    // Slot fill/drain and pointer advance past the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= 3'd0;
            r_slot_valid <= 1'b0;
            r_slot_data  <= '0;
        end else if (w_pop) begin
            r_slot_data  <= arb.rx_items[w_grant_idx*ITEM_W +: ITEM_W];
            r_slot_valid <= 1'b1;
            r_ptr        <= (w_grant_idx == 3'd4) ? 3'd0 : w_grant_idx + 3'd1;
        end else if (w_fifo_write) begin
            r_slot_valid <= 1'b0;
        end
    end

`ifdef RX_ARB_STATS_EN
    logic [4:0][STAT_W-1:0] r_stat_cnt;

    // Saturating per-port grant counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_cnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (w_rx_read[i] && (r_stat_cnt[i] != {STAT_W{1'b1}}))
                    r_stat_cnt[i] <= r_stat_cnt[i] + 1'b1;
            end
        end
    end

    // Readback mux; indices 5-7 read as zero
    always_comb begin
        arb.stat_count = '0;
        if (arb.stat_sel <= 3'd4) arb.stat_count = r_stat_cnt[arb.stat_sel];
    end
`else
    assign arb.stat_count = '0;
`endif

endmodule

// File: tb/tb_rx_rr_arbiter.sv
// Directed bench for rx_rr_arbiter: a vector table for the cycle-by-cycle
// grant/drain behaviour, plus hand sequences for stats and async reset.
module tb_rx_rr_arbiter;

    localparam int ITEM_W = 8;
    localparam int STAT_W = 16;

    logic clk;
    logic reset;

    rx_rr_arbiter_if #(.ITEM_W(ITEM_W), .STAT_W(STAT_W)) arb_if ();

    rx_rr_arbiter #(.ITEM_W(ITEM_W), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  valid;
        logic [39:0] items;
        logic        full;
        logic [4:0]  exp_read;
        logic        exp_wr;
        logic [7:0]  exp_item;
    } vec_t;

    localparam logic [39:0] DEF = 40'hA4A3A2A1A0;
    vec_t vt [21];

    initial begin
        // Sequence starts straight after reset: ptr=0, slot empty
        vt[0]  = '{5'b00001, 40'hA4A3A2A111, 1'b0, 5'b00001, 1'b0, 8'h00};
        vt[1]  = '{5'b00000, DEF,            1'b0, 5'b00000, 1'b1, 8'h11};
        vt[2]  = '{5'b11111, DEF,            1'b0, 5'b00010, 1'b0, 8'h11};
        vt[3]  = '{5'b11111, DEF,            1'b0, 5'b00100, 1'b1, 8'hA1};
        vt[4]  = '{5'b11111, DEF,            1'b0, 5'b01000, 1'b1, 8'hA2};
        vt[5]  = '{5'b11111, DEF,            1'b0, 5'b10000, 1'b1, 8'hA3};
        vt[6]  = '{5'b11111, DEF,            1'b0, 5'b00001, 1'b1, 8'hA4};
        vt[7]  = '{5'b11111, DEF,            1'b0, 5'b00010, 1'b1, 8'hA0};
        vt[8]  = '{5'b00011, DEF,            1'b0, 5'b00001, 1'b1, 8'hA1};
        vt[9]  = '{5'b00000, DEF,            1'b0, 5'b00000, 1'b1, 8'hA0};
        vt[10] = '{5'b00100, 40'hA4A333A1A0, 1'b0, 5'b00100, 1'b0, 8'hA0};
        vt[11] = '{5'b00010, DEF,            1'b1, 5'b00000, 1'b0, 8'h33};
        vt[12] = '{5'b00010, DEF,            1'b1, 5'b00000, 1'b0, 8'h33};
        vt[13] = '{5'b00010, DEF,            1'b1, 5'b00000, 1'b0, 8'h33};
        vt[14] = '{5'b00010, DEF,            1'b1, 5'b00000, 1'b0, 8'h33};
        vt[15] = '{5'b00010, DEF,            1'b0, 5'b00010, 1'b1, 8'h33};
        vt[16] = '{5'b00000, DEF,            1'b0, 5'b00000, 1'b1, 8'hA1};
        vt[17] = '{5'b00000, DEF,            1'b0, 5'b00000, 1'b0, 8'hA1};
        vt[18] = '{5'b00001, DEF,            1'b1, 5'b00001, 1'b0, 8'hA1};
        vt[19] = '{5'b00001, DEF,            1'b1, 5'b00000, 1'b0, 8'hA0};
        vt[20] = '{5'b00000, DEF,            1'b0, 5'b00000, 1'b1, 8'hA0};

        arb_if.rx_valid  = '0;
        arb_if.rx_items  = DEF;
        arb_if.fifo_full = 1'b0;
        arb_if.stat_sel  = 3'd0;
        reset = 1'b1;
        #1;
        chk("reset_fifo_write", 32'(arb_if.fifo_write), 32'd0);
        chk("reset_fifo_item",  32'(arb_if.fifo_item),  32'd0);
        chk("reset_rx_read",    32'(arb_if.rx_read),    32'd0);
        chk("reset_stat_count", 32'(arb_if.stat_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            arb_if.rx_valid  = vt[i].valid;
            arb_if.rx_items  = vt[i].items;
            arb_if.fifo_full = vt[i].full;
            #1;
            chk($sformatf("v%0d_rx_read", i),    32'(arb_if.rx_read),    32'(vt[i].exp_read));
            chk($sformatf("v%0d_fifo_write", i), 32'(arb_if.fifo_write), 32'(vt[i].exp_wr));
            chk($sformatf("v%0d_fifo_item", i),  32'(arb_if.fifo_item),  32'(vt[i].exp_item));
            @(negedge clk);
        end

        // Stats: grants so far are port0 x4, port1 x3, port2 x2, port3 x1, port4 x1
        arb_if.rx_valid  = '0;
        arb_if.fifo_full = 1'b0;
        arb_if.rx_items  = DEF;
        for (int s = 0; s < 8; s++) begin
            logic [15:0] exp_cnt;
`ifdef RX_ARB_STATS_EN
            case (s)
                0: exp_cnt = 16'd4;
                1: exp_cnt = 16'd3;
                2: exp_cnt = 16'd2;
                3: exp_cnt = 16'd1;
                4: exp_cnt = 16'd1;
                default: exp_cnt = 16'd0;
            endcase
`else
            exp_cnt = 16'd0;
`endif
            arb_if.stat_sel = 3'(s);
            #1;
            chk($sformatf("stat_count_sel%0d", s), 32'(arb_if.stat_count), 32'(exp_cnt));
        end

`ifdef RX_ARB_STATS_EN
        // Saturation: keep port 2 granted every cycle well past 2^STAT_W
        arb_if.rx_valid = 5'b00100;
        arb_if.stat_sel = 3'd2;
        for (int c = 0; c < 65540; c++) @(negedge clk);
        arb_if.rx_valid = '0;
        #1;
        chk("stat_saturate", 32'(arb_if.stat_count), 32'h0000FFFF);
        @(negedge clk);
        @(negedge clk);
`endif

        // Async reset with a full slot: write must drop without a clock edge
        @(negedge clk);
        arb_if.rx_valid = 5'b01000;
        @(negedge clk);
        arb_if.rx_valid = '0;
        arb_if.fifo_full = 1'b1;
        #1;
        chk("pre_reset_slot_held", 32'(arb_if.fifo_item), 32'hA3);
        arb_if.fifo_full = 1'b0;
        #1;
        chk("pre_reset_fifo_write", 32'(arb_if.fifo_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_fifo_write", 32'(arb_if.fifo_write), 32'd0);
        chk("async_reset_fifo_item",  32'(arb_if.fifo_item),  32'd0);
        chk("async_reset_stat",       32'(arb_if.stat_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // ptr back at 0: all ports valid must grant N first
        arb_if.rx_valid = 5'b11111;
        #1;
        chk("post_reset_grant", 32'(arb_if.rx_read), 32'b00001);
        @(negedge clk);
        arb_if.rx_valid = '0;
        #1;
        chk("post_reset_item", 32'(arb_if.fifo_item), 32'hA0);
        chk("post_reset_write", 32'(arb_if.fifo_write), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
